// File: rtl/top_pkg.sv
// Shared types and sizing helpers for the LP -> systolic-array datapath.
package top_pkg;

  localparam int TOP_CHUNK_SIZE = 16;
  localparam int TOP_BLOCK_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } west_ctrl_state_t;

  // $clog2 floored at 1 so single-entry configurations still get a 1-bit field.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/west_rd_sequencer.sv
// Read side of the west buffer: issues port-B reads, replays the buffer PASSES
// times and tracks the output valid/last flags that follow the one-cycle RAM latency.
module west_rd_sequencer
  import top_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int PASSES = 2,
  parameter int AW     = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_fill,
  input  logic          i_drain,
  input  logic [AW-1:0] i_wr_ptr,
  input  logic          i_sa_ready,
  output logic          o_enb,
  output logic [AW-1:0] o_addrb,
  output logic          o_sa_valid,
  output logic          o_sa_last,
  output logic          o_last_done
);

  localparam int             PW        = clog2_min1(PASSES);
  localparam logic [AW-1:0]  LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [PW-1:0]  LAST_PASS = PW'(PASSES - 1);

  logic [AW-1:0] r_rd_ptr;
  logic [PW-1:0] r_pass_cnt;
  logic          r_done;
  logic          r_sa_valid;
  logic          r_sa_last;

  logic w_rd_allowed;
  logic w_issue;
  logic w_wrap;
  logic w_final;

  // During a fill only pass 0 may read, and only words already written.
  assign w_rd_allowed = ~r_done &
                        (i_drain | (i_fill & (r_pass_cnt == '0) & (r_rd_ptr < i_wr_ptr)));
  // RAM output holds when port B is idle, so stalling the issue is the skid buffer.
  assign w_issue      = w_rd_allowed & (~r_sa_valid | i_sa_ready);
  assign w_wrap       = (r_rd_ptr == LAST_ADDR);
  assign w_final      = w_wrap & (r_pass_cnt == LAST_PASS);

  assign o_enb        = w_issue;
  assign o_addrb      = r_rd_ptr;
  assign o_sa_valid   = r_sa_valid;
  assign o_sa_last    = r_sa_last;
  assign o_last_done  = r_sa_valid & i_sa_ready & r_sa_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr   <= '0;
      r_pass_cnt <= '0;
      r_done     <= 1'b0;
      r_sa_valid <= 1'b0;
      r_sa_last  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_sa_valid <= 1'b1;
        r_sa_last  <= w_final;
        if (w_wrap) begin
          r_rd_ptr <= '0;
          if (w_final) begin
            r_done <= 1'b1;
          end else begin
            r_pass_cnt <= r_pass_cnt + 1'b1;
          end
        end else begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
      end else if (i_sa_ready) begin
        r_sa_valid <= 1'b0;
        r_sa_last  <= 1'b0;
      end

      if (o_last_done) begin
        r_done     <= 1'b0;
        r_pass_cnt <= '0;
        r_rd_ptr   <= '0;
      end
    end
  end

endmodule

// File: rtl/west_buffer_ctrl.sv
// West buffer sequencer: LP fill over valid/ready, multi-pass replay to the SA.
// Define WEST_CTRL_OVERLAP_EN to let pass-0 reads trail writes during the fill.
module west_buffer_ctrl
  import top_pkg::*;
#(
  parameter int  TOTAL_MODULES = TOP_BLOCK_SIZE,
  parameter int  COL_X         = TOP_CHUNK_SIZE,
  parameter int  TOTAL_INPUT_W = 2,
  parameter int  PASSES        = 2,
  localparam int TOTAL_DEPTH   = COL_X * TOTAL_INPUT_W,
  localparam int ADDR_WIDTH    = clog2_min1(TOTAL_DEPTH),
  localparam int SLICE_W       = clog2_min1(TOTAL_MODULES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SLICE_W-1:0]    slice_sel,
  input  logic                  lp_valid,
  output logic                  lp_ready,
  input  logic                  sa_ready,
  output logic                  sa_valid,
  output logic                  sa_last,
  output logic [SLICE_W-1:0]    w_slicing_idx,
  output logic                  w_ena,
  output logic                  w_wea,
  output logic [ADDR_WIDTH-1:0] w_addra,
  output logic                  w_enb,
  output logic                  w_web,
  output logic [ADDR_WIDTH-1:0] w_addrb,
  output logic                  busy
);

  localparam logic [ADDR_WIDTH-1:0] LAST_WR = ADDR_WIDTH'(TOTAL_DEPTH - 1);

  west_ctrl_state_t        r_state;
  west_ctrl_state_t        w_state_next;
  logic [ADDR_WIDTH-1:0]   r_wr_ptr;
  logic [SLICE_W-1:0]      r_slice;

  logic w_wr_fire;
  logic w_wr_last;
  logic w_drain;
  logic w_rd_fill;
  logic w_last_done;

  assign w_wr_fire = lp_valid & lp_ready;
  assign w_wr_last = (r_wr_ptr == LAST_WR);

`ifdef WEST_CTRL_OVERLAP_EN
  assign w_rd_fill = (r_state == FILL);
`else
  assign w_rd_fill = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_wr_fire) w_state_next = w_wr_last ? DRAIN : FILL;
      FILL:    if (w_wr_fire && w_wr_last) w_state_next = DRAIN;
      DRAIN:   if (w_last_done) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // lp_ready is masked by rst so nothing is accepted while the block is held in reset.
  always_comb begin
    lp_ready = 1'b0;
    w_drain  = 1'b0;
    busy     = 1'b0;
    case (r_state)
      IDLE:  lp_ready = ~rst;
      FILL: begin
        lp_ready = ~rst;
        busy     = 1'b1;
      end
      DRAIN: begin
        w_drain = 1'b1;
        busy    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_slice  <= '0;
    end else if (w_wr_fire) begin
      r_wr_ptr <= w_wr_last ? '0 : r_wr_ptr + 1'b1;
      if (r_state == IDLE) begin
        r_slice <= slice_sel;
      end
    end
  end

  assign w_ena         = w_wr_fire;
  assign w_wea         = w_wr_fire;
  assign w_addra       = r_wr_ptr;
  assign w_web         = 1'b0;
  assign w_slicing_idx = r_slice;

  west_rd_sequencer #(
    .DEPTH  (TOTAL_DEPTH),
    .PASSES (PASSES),
    .AW     (ADDR_WIDTH)
  ) u_rd_seq (
    .clk         (clk),
    .rst         (rst),
    .i_fill      (w_rd_fill),
    .i_drain     (w_drain),
    .i_wr_ptr    (r_wr_ptr),
    .i_sa_ready  (sa_ready),
    .o_enb       (w_enb),
    .o_addrb     (w_addrb),
    .o_sa_valid  (sa_valid),
    .o_sa_last   (sa_last),
    .o_last_done (w_last_done)
  );

endmodule

// File: tb/tb_west_buffer_ctrl.sv
// Bench for west_buffer_ctrl with a behavioural TDPRAM on its port pins.
// Expected latencies follow WEST_CTRL_OVERLAP_EN if it is defined for the build.
`timescale 1ns/1ps
module tb_west_buffer_ctrl;

  localparam int DEPTH  = 32;
  localparam int PASSES = 2;
  localparam int AW     = 5;
  localparam int SW     = 2;
  localparam int WORDS  = DEPTH * PASSES;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] slice_sel = '0;
  logic          lp_valid = 1'b0;
  logic          lp_ready;
  logic          sa_ready = 1'b0;
  logic          sa_valid;
  logic          sa_last;
  logic [SW-1:0] w_slicing_idx;
  logic          w_ena, w_wea, w_enb, w_web;
  logic [AW-1:0] w_addra, w_addrb;
  logic          busy;

  logic [15:0]   lp_data = '0;
  logic [15:0]   doutb;
  logic [15:0]   mem [0:DEPTH-1];
  logic [15:0]   sb_q [$];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  west_buffer_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .slice_sel     (slice_sel),
    .lp_valid      (lp_valid),
    .lp_ready      (lp_ready),
    .sa_ready      (sa_ready),
    .sa_valid      (sa_valid),
    .sa_last       (sa_last),
    .w_slicing_idx (w_slicing_idx),
    .w_ena         (w_ena),
    .w_wea         (w_wea),
    .w_addra       (w_addra),
    .w_enb         (w_enb),
    .w_web         (w_web),
    .w_addrb       (w_addrb),
    .busy          (busy)
  );

  // The buffer the controller drives: write port A, registered read port B.
  always @(posedge clk) begin
    if (w_ena && w_wea) mem[w_addra] <= lp_data;
    if (w_enb) doutb <= mem[w_addrb];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int        period;
    int        rdy_mode;
    bit        hold;
    logic [SW-1:0] slice;
    int        lat_ovl;
    int        lat_no;
    int        span;
  } vec_t;

  vec_t vecs [5];

  task automatic run_fill(input int fid, input int period, input int rdy_mode, input bit hold,
                          input logic [SW-1:0] slice, input int abort_at,
                          input int exp_lat, input int exp_span);
    int k = 0, beat = 0, words = 0, first_wr = -1, first_v = -1, last_v = -1;
    bit acc, fire, done = 0, busy_exp = 0, held = 0;
    logic [15:0] held_data, exp_word;
    while (!done) begin
      lp_valid  = (beat < DEPTH) ? ((k % period) == 0) : hold;
      lp_data   = {fid[7:0], beat[7:0]};
      slice_sel = (beat == 0) ? slice : ~slice;
      case (rdy_mode)
        0:       sa_ready = 1'b1;
        1:       sa_ready = ((k % 3) == 0);
        default: sa_ready = 1'($urandom_range(0, 1));
      endcase

      @(negedge clk);
      acc = lp_valid && lp_ready;
      if (lp_valid && beat < DEPTH) begin
        chk("lp_ready_fill", lp_ready, 1);
        chk("w_addra", w_addra, beat);
        chk("w_ena_wea", w_ena & w_wea, 1);
        if (beat == 0) begin
          first_wr = k;
          for (int p = 0; p < PASSES; p++)
            for (int i = 0; i < DEPTH; i++) sb_q.push_back({fid[7:0], i[7:0]});
        end
      end else if (lp_valid) begin
        chk("lp_ready_drain", lp_ready, 0);
        chk("no_write_drain", w_ena, 0);
      end
      chk("busy", busy, busy_exp);

      if (sa_valid && first_v < 0) first_v = k;
      if (sa_valid && !sa_ready) begin
        if (held) chk("hold_stable", doutb, held_data);
        held = 1;
        held_data = doutb;
      end else begin
        held = 0;
      end

      fire = sa_valid && sa_ready;
      if (fire) begin
        words++;
        last_v = k;
        if (sb_q.size() == 0) begin
          chk("sb_extra_word", words, 0);
        end else begin
          exp_word = sb_q.pop_front();
          chk("sa_data", doutb, exp_word);
          chk("sa_last", sa_last, (sb_q.size() == 0));
        end
        if (sa_last || words == abort_at) done = 1;
      end

      @(posedge clk);
      #1;
      if (acc) begin
        if (beat == 0) busy_exp = 1;
        beat++;
      end
      k++;
      if (k > 2000) begin
        chk("fill_timeout", k, 0);
        done = 1;
      end
    end

    if (abort_at == 0) begin
      chk("word_count", words, WORDS);
      chk("first_valid_lat", first_v - first_wr, exp_lat);
      chk("slice_idx", w_slicing_idx, slice);
      chk("busy_after", busy, 0);
      chk("lp_ready_after", lp_ready, 1);
      if (exp_span > 0) chk("valid_span", last_v - first_v + 1, exp_span);
    end
  endtask

  function automatic int pick_lat(input vec_t v);
`ifdef WEST_CTRL_OVERLAP_EN
    return v.lat_ovl;
`else
    return v.lat_no;
`endif
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // period, ready mode (0 always, 1 = 1,0,0 pattern, 2 random), hold lp_valid, slice,
    // first-valid latency with/without overlap, consecutive-valid span (0 = not checked)
    vecs[0] = '{1, 0, 1'b0, 2'd2, 2, 33, 64};
    vecs[1] = '{1, 1, 1'b0, 2'd1, 2, 33, 0};
    vecs[2] = '{3, 0, 1'b0, 2'd0, 2, 95, 0};
    vecs[3] = '{1, 2, 1'b1, 2'd2, 2, 33, 0};
    vecs[4] = '{1, 0, 1'b0, 2'd3, 2, 33, 64};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_lp_ready", lp_ready, 0);
    chk("rst_sa_valid", sa_valid, 0);
    chk("rst_sa_last", sa_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_w_ena", w_ena, 0);
    chk("rst_w_enb", w_enb, 0);
    chk("rst_w_addra", w_addra, 0);
    chk("rst_w_addrb", w_addrb, 0);
    chk("rst_slice", w_slicing_idx, 0);
    rst = 1'b0;
    #1;
    chk("idle_lp_ready", lp_ready, 1);

    for (int v = 0; v < 5; v++)
      run_fill(v + 1, vecs[v].period, vecs[v].rdy_mode, vecs[v].hold, vecs[v].slice,
               0, pick_lat(vecs[v]), vecs[v].span);

    // Abort after the tenth word, then a normal fill must follow.
    run_fill(6, 1, 0, 1'b0, 2'd1, 10, 0, 0);
    rst = 1'b1;
    lp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_sa_valid", sa_valid, 0);
    chk("midrst_sa_last", sa_last, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_lp_ready", lp_ready, 1);
    chk("midrst_w_enb", w_enb, 0);
    chk("midrst_w_addra", w_addra, 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    run_fill(7, 1, 0, 1'b0, 2'd2, 0, pick_lat(vecs[0]), 64);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
